bht_gshare_mp: RTL and testbench
================================

Name: bht_gshare_mp

Overview:
- Parametrised successor to the frontend bimodal BHT. Adds configurable counter width, multiple predictions per fetch block, an optional gshare index (PC XOR global history) and a sequential flush engine.
- Sits in the frontend beside the BTB/RAS.
- Predicts combinationally from the fetch vPC.
- Trains from the resolved-branch update port driven by the execute stage.

Parameters:
- NR_ENTRIES, 1024, total counters; power of two, at least 2*INSTR_PER_FETCH.
- INSTR_PER_FETCH, 2, 16-bit instruction slots per fetch block; power of two.
- CTR_BITS, 2, saturating counter width; range 2..4.
- HIST_BITS, 8, global history length; must be at most IDX_BITS.
- GSHARE, 1, 1 = index XOR history; 0 = pure bimodal, ghr still maintained.
- VLEN, 64, virtual address width.

Derived values:
- NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH
- ROW_BITS = log2(INSTR_PER_FETCH)
- IDX_BITS = log2(NR_ROWS)
- OFFSET = 1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  one-cycle pulse; starts a table flush
- flush_busy_o  out  1  flush walk in progress
- vpc_i  in  VLEN  fetch-block virtual PC
- ghr_o  out  HIST_BITS  current global history; frontend carries it with the branch
- bht_prediction_valid_o  out  INSTR_PER_FETCH  per-slot entry valid
- bht_prediction_taken_o  out  INSTR_PER_FETCH  per-slot counter MSB
- bht_update_valid_i  in  1  resolved conditional branch
- bht_update_pc_i  in  VLEN  PC of resolved branch
- bht_update_ghr_i  in  HIST_BITS  ghr snapshot captured when that branch was predicted
- bht_update_taken_i  in  1  resolved direction

Behaviour:
- Reset and signal definitions:
  - Clock is clk_i; reset is rst_i, synchronous and active-high.
  - Reset clears all valid bits and sets every counter to WNT = 2^(CTR_BITS-1)-1.
  - Reset sets ghr to 0, FSM to IDLE and flush_busy_o to 0.
  - Prediction outputs are 0 out of reset.
- Indexing:
  - col(pc) = pc[OFFSET+ROW_BITS-1:OFFSET]
  - raw(pc) = pc[OFFSET+ROW_BITS+IDX_BITS-1:OFFSET+ROW_BITS]
  - row = raw XOR zero-extended history when GSHARE=1, else row = raw.
  - Prediction uses ghr_o. Update uses bht_update_ghr_i.
- Prediction:
  - Combinational, zero latency, reading row(vpc_i).
  - Slot i reports valid = entry valid, taken = counter MSB.
  - During FLUSH all valid outputs are forced to 0.
- Update (one per cycle, written at the clock edge):
  - Invalid entry: counter = taken ? WNT+1 : WNT, valid = 1.
  - Valid entry, taken: counter increments and saturates at 2^CTR_BITS-1.
  - Valid entry, not taken: counter decrements and saturates at 0.
  - ghr <= {ghr[HIST_BITS-2:0], taken} on every accepted update; the reset value 0 is the only exception.
- Same-cycle prediction and update to the same entry: the prediction returns the pre-update value.
- FSM:
  - IDLE --flush_i--> FLUSH, with ptr = 0 and busy = 1.
  - FLUSH: each cycle, row ptr gets all valid bits cleared and counters set to WNT; ptr++.
  - When ptr = NR_ROWS-1, FLUSH -> IDLE next cycle.
  - Flush takes exactly NR_ROWS cycles. ghr is cleared on entry to FLUSH.
- Boundary rules:
  - flush_i during FLUSH is ignored; the walk does not restart.
  - bht_update_valid_i during FLUSH is dropped: no table write, no ghr shift.
  - Update in the same cycle as flush_i is dropped.
  - rst_i mid-flush aborts the walk and performs full reset.
  - ptr width is IDX_BITS+1 so the final row compare cannot wrap.
- Storage model: one row-write port per cycle, shared by update and flush; the flush has priority.

Test Plan:
- Reset, then vpc_i=0x1000 -> both valid=0 and taken=0; ghr_o=0; flush_busy_o=0.
- GSHARE=0, four taken updates to pc 0x1002 -> counter 01→10→11→11 (saturates); predicting vpc 0x1000 gives slot1 valid=1, taken=1 and slot0 valid=0; ghr_o=0x0F.
- Alias check:
  - Setup: GSHARE=1, update pc 0x2000 with ghr snapshot 0x00 and taken=1.
  - Read with ghr=0x00 -> taken=1.
  - Read the same pc with ghr_o forced via four not-taken updates to a different pc (ghr=0x10 then 0x0) -> the entry is reached at row raw^ghr; the bench checks row selection against the model.
- Same-cycle read/update of a WNT entry (taken=1) -> that cycle shows taken=0; the next cycle shows taken=1.
- flush_i pulse with NR_ENTRIES=16, IPF=2:
  - flush_busy_o is high for exactly 8 cycles.
  - A second flush_i and an update in cycle 3 have no effect.
  - Afterwards all entries are invalid and ghr_o=0.
- rst_i asserted in cycle 4 of a flush -> the next cycle has flush_busy_o=0 and all entries invalid; a subsequent update proceeds normally.

Source files
------------

// File: rtl/bht_gshare_mp.sv
// Branch history table with saturating counters, multiple slots per fetch block,
// optional gshare indexing and a row-at-a-time flush walk.
module bht_gshare_mp #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned HIST_BITS       = 8,
  parameter int unsigned GSHARE          = 1,
  parameter int unsigned VLEN            = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  output logic                       flush_busy_o,
  input  logic [VLEN-1:0]            vpc_i,
  output logic [HIST_BITS-1:0]       ghr_o,
  output logic [INSTR_PER_FETCH-1:0] bht_prediction_valid_o,
  output logic [INSTR_PER_FETCH-1:0] bht_prediction_taken_o,
  input  logic                       bht_update_valid_i,
  input  logic [VLEN-1:0]            bht_update_pc_i,
  input  logic [HIST_BITS-1:0]       bht_update_ghr_i,
  input  logic                       bht_update_taken_i
);

  localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned COL_W    = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int unsigned IDX_BITS = $clog2(NR_ROWS);
  localparam int unsigned OFFSET   = 1;

  localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [IDX_BITS:0]   PTR_LAST = (IDX_BITS + 1)'(NR_ROWS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  typedef logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] ctr_row_t;

  logic [INSTR_PER_FETCH-1:0] valid_q [NR_ROWS];
  ctr_row_t                   ctr_q   [NR_ROWS];

  logic [0:0]           state_q, state_d;
  logic [IDX_BITS:0]    ptr_q, ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  logic                       wr_en;
  logic [IDX_BITS-1:0]        wr_row;
  logic [INSTR_PER_FETCH-1:0] wr_valid;
  ctr_row_t                   wr_ctr;

  logic [IDX_BITS-1:0] pred_row;
  logic [IDX_BITS-1:0] upd_row;
  logic [COL_W-1:0]    upd_col;
  logic [CTR_BITS-1:0] upd_cur;
  logic [CTR_BITS-1:0] upd_next;

  function automatic logic [IDX_BITS-1:0] row_of(input logic [VLEN-1:0]      pc,
                                                 input logic [HIST_BITS-1:0] hist);
    logic [IDX_BITS-1:0] raw;
    raw = IDX_BITS'(pc >> (OFFSET + ROW_BITS));
    return (GSHARE != 0) ? (raw ^ IDX_BITS'(hist)) : raw;
  endfunction

  function automatic logic [COL_W-1:0] col_of(input logic [VLEN-1:0] pc);
    return COL_W'((pc >> OFFSET) & VLEN'(INSTR_PER_FETCH - 1));
  endfunction

  // Prediction reads the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    pred_row = row_of(vpc_i, ghr_q);
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      bht_prediction_valid_o[i] = valid_q[pred_row][i] & (state_q == IDLE);
      bht_prediction_taken_o[i] = ctr_q[pred_row][i][CTR_BITS-1];
    end
  end

  assign ghr_o        = ghr_q;
  assign flush_busy_o = (state_q == FLUSH);

  always_comb begin
    upd_row = row_of(bht_update_pc_i, bht_update_ghr_i);
    upd_col = col_of(bht_update_pc_i);
    upd_cur = ctr_q[upd_row][upd_col];
    if (!valid_q[upd_row][upd_col]) begin
      upd_next = bht_update_taken_i ? WNT + 1'b1 : WNT;
    end else if (bht_update_taken_i) begin
      upd_next = (upd_cur == CTR_MAX) ? upd_cur : upd_cur + 1'b1;
    end else begin
      upd_next = (upd_cur == '0) ? upd_cur : upd_cur - 1'b1;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ghr_d    = ghr_q;
    wr_en    = 1'b0;
    wr_row   = upd_row;
    wr_valid = valid_q[upd_row];
    wr_ctr   = ctr_q[upd_row];

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          ptr_d   = '0;
          ghr_d   = '0;
        end else if (bht_update_valid_i) begin
          wr_en             = 1'b1;
          wr_valid[upd_col] = 1'b1;
          wr_ctr[upd_col]   = upd_next;
          ghr_d             = HIST_BITS'({ghr_q, bht_update_taken_i});
        end
      end
      FLUSH: begin
        // The walk owns the single row-write port; updates and new flush requests are dropped.
        wr_en    = 1'b1;
        wr_row   = ptr_q[IDX_BITS-1:0];
        wr_valid = '0;
        wr_ctr   = {INSTR_PER_FETCH{WNT}};
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ghr_q   <= '0;
      // NOTE: the table is reset row by row because valid bits must be clear after reset;
      // this keeps it in flops rather than a RAM macro.
      for (int r = 0; r < NR_ROWS; r++) begin
        valid_q[r] <= '0;
        ctr_q[r]   <= {INSTR_PER_FETCH{WNT}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      if (wr_en) begin
        valid_q[wr_row] <= wr_valid;
        ctr_q[wr_row]   <= wr_ctr;
      end
    end
  end

endmodule

// File: tb/tb_bht_gshare_mp.sv
// Scoreboard bench for bht_gshare_mp: three instances (bimodal, large gshare, small gshare
// used for the flush walk); expectations are queued per cycle and compared on the falling edge.
`timescale 1ns/1ps
module tb_bht_gshare_mp;

  typedef struct packed {
    int         dut;
    logic [1:0] valid;
    logic [1:0] taken;
    logic [7:0] ghr;
    logic       busy;
    int         cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_b: bimodal, 1024 entries
  logic [63:0] vpc_b = '0, upc_b = '0;
  logic        uv_b = 0, ut_b = 0, fl_b = 0, busy_b;
  logic [7:0]  ug_b = '0, ghr_b;
  logic [1:0]  pv_b, pt_b;
  // dut_g: gshare, 1024 entries, 8-bit history
  logic [63:0] vpc_g = '0, upc_g = '0;
  logic        uv_g = 0, ut_g = 0, fl_g = 0, busy_g;
  logic [7:0]  ug_g = '0, ghr_g;
  logic [1:0]  pv_g, pt_g;
  // dut_f: gshare, 16 entries (8 rows), 3-bit history
  logic [63:0] vpc_f = '0, upc_f = '0;
  logic        uv_f = 0, ut_f = 0, fl_f = 0, busy_f;
  logic [2:0]  ug_f = '0, ghr_f;
  logic [1:0]  pv_f, pt_f;

  bht_gshare_mp #(.NR_ENTRIES(1024), .INSTR_PER_FETCH(2), .CTR_BITS(2), .HIST_BITS(8),
                  .GSHARE(0), .VLEN(64)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(fl_b), .flush_busy_o(busy_b), .vpc_i(vpc_b),
    .ghr_o(ghr_b), .bht_prediction_valid_o(pv_b), .bht_prediction_taken_o(pt_b),
    .bht_update_valid_i(uv_b), .bht_update_pc_i(upc_b), .bht_update_ghr_i(ug_b),
    .bht_update_taken_i(ut_b));

  bht_gshare_mp #(.NR_ENTRIES(1024), .INSTR_PER_FETCH(2), .CTR_BITS(2), .HIST_BITS(8),
                  .GSHARE(1), .VLEN(64)) dut_g (
    .clk_i(clk), .rst_i(rst), .flush_i(fl_g), .flush_busy_o(busy_g), .vpc_i(vpc_g),
    .ghr_o(ghr_g), .bht_prediction_valid_o(pv_g), .bht_prediction_taken_o(pt_g),
    .bht_update_valid_i(uv_g), .bht_update_pc_i(upc_g), .bht_update_ghr_i(ug_g),
    .bht_update_taken_i(ut_g));

  bht_gshare_mp #(.NR_ENTRIES(16), .INSTR_PER_FETCH(2), .CTR_BITS(2), .HIST_BITS(3),
                  .GSHARE(1), .VLEN(64)) dut_f (
    .clk_i(clk), .rst_i(rst), .flush_i(fl_f), .flush_busy_o(busy_f), .vpc_i(vpc_f),
    .ghr_o(ghr_f), .bht_prediction_valid_o(pv_f), .bht_prediction_taken_o(pt_f),
    .bht_update_valid_i(uv_f), .bht_update_pc_i(upc_f), .bht_update_ghr_i(ug_f),
    .bht_update_taken_i(ut_f));

  // Monitor: pops every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t       e;
    string      nm;
    logic [1:0] v, t;
    logic [7:0] g;
    logic       b;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e.dut)
        0:       begin v = pv_b; t = pt_b; g = ghr_b;          b = busy_b; end
        1:       begin v = pv_g; t = pt_g; g = ghr_g;          b = busy_g; end
        default: begin v = pv_f; t = pt_f; g = {5'b0, ghr_f}; b = busy_f; end
      endcase
      checks++;
      if (e.cyc != cyc || v !== e.valid || t !== e.taken || g !== e.ghr || b !== e.busy) begin
        errors++;
        $display("FAIL %s (cycle %0d): got valid=%b taken=%b ghr=%h busy=%b, want valid=%b taken=%b ghr=%h busy=%b",
                 nm, cyc, v, t, g, b, e.valid, e.taken, e.ghr, e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int dut, input string nm, input logic [1:0] v,
                            input logic [1:0] t, input logic [7:0] g, input logic b);
    exp_t e;
    e.dut = dut; e.valid = v; e.taken = t; e.ghr = g; e.busy = b; e.cyc = cyc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic upd_b(input logic [63:0] pc, input logic [7:0] h, input logic tk);
    uv_b = 1'b1; upc_b = pc; ug_b = h; ut_b = tk;
    tick();
    uv_b = 1'b0;
  endtask

  task automatic upd_g(input logic [63:0] pc, input logic [7:0] h, input logic tk);
    uv_g = 1'b1; upc_g = pc; ug_g = h; ut_g = tk;
    tick();
    uv_g = 1'b0;
  endtask

  task automatic upd_f(input logic [63:0] pc, input logic [2:0] h, input logic tk);
    uv_f = 1'b1; upc_f = pc; ug_f = h; ut_f = tk;
    tick();
    uv_f = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vpc_b = 64'h1000; vpc_g = 64'h1000; vpc_f = 64'h1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    expect_out(0, "reset_b", 2'b00, 2'b00, 8'h00, 1'b0);
    expect_out(1, "reset_g", 2'b00, 2'b00, 8'h00, 1'b0);
    expect_out(2, "reset_f", 2'b00, 2'b00, 8'h00, 1'b0);
    tick();

    // Bimodal: pc 0x1002 -> row 0, slot 1; counter 01->10->11->11->11
    vpc_b = 64'h1000;
    upd_b(64'h1002, 8'h00, 1'b1);
    expect_out(0, "bim_first_taken", 2'b10, 2'b10, 8'h01, 1'b0);
    repeat (3) upd_b(64'h1002, 8'h00, 1'b1);
    expect_out(0, "bim_saturate_hi", 2'b10, 2'b10, 8'h0F, 1'b0);
    upd_b(64'h1002, 8'h00, 1'b0);
    expect_out(0, "bim_dec_to_10", 2'b10, 2'b10, 8'h1E, 1'b0);
    upd_b(64'h1002, 8'h00, 1'b0);
    expect_out(0, "bim_dec_to_01", 2'b10, 2'b00, 8'h3C, 1'b0);
    repeat (2) upd_b(64'h1002, 8'h00, 1'b0);
    upd_b(64'h1002, 8'h00, 1'b1);
    expect_out(0, "bim_saturate_lo", 2'b10, 2'b00, 8'hE1, 1'b0);
    tick();

    // Gshare alias: pc 0x2000 with snapshot 0 writes row 0 slot 0; ghr becomes 0x01
    upd_g(64'h2000, 8'h00, 1'b1);
    vpc_g = 64'h2004;
    expect_out(1, "gs_row0_via_h01", 2'b01, 2'b01, 8'h01, 1'b0);
    repeat (4) upd_g(64'h3002, 8'h80, 1'b0);
    vpc_g = 64'h2000;
    expect_out(1, "gs_pc2000_h10", 2'b00, 2'b00, 8'h10, 1'b0);
    tick();
    vpc_g = 64'h2040;
    expect_out(1, "gs_row0_via_h10", 2'b01, 2'b01, 8'h10, 1'b0);
    repeat (4) upd_g(64'h3002, 8'h80, 1'b0);
    vpc_g = 64'h2000;
    expect_out(1, "gs_pc2000_h00", 2'b01, 2'b01, 8'h00, 1'b0);
    tick();
    vpc_g = 64'h0200;
    expect_out(1, "gs_row80_slot1", 2'b10, 2'b00, 8'h00, 1'b0);
    tick();

    // Same-cycle read/update of a WNT entry (row 1, slot 1)
    upd_g(64'h4006, 8'h00, 1'b0);
    vpc_g = 64'h4004;
    uv_g = 1'b1; upc_g = 64'h4006; ug_g = 8'h00; ut_g = 1'b1;
    expect_out(1, "gs_same_cycle_old", 2'b10, 2'b00, 8'h00, 1'b0);
    tick();
    uv_g = 1'b0;
    vpc_g = 64'h4000;
    expect_out(1, "gs_next_cycle_new", 2'b10, 2'b10, 8'h01, 1'b0);
    tick();

    // Small table: populate rows 0, 3, 7 then flush
    upd_f(64'h00, 3'd0, 1'b1);
    upd_f(64'h0E, 3'd0, 1'b1);
    upd_f(64'h1C, 3'd0, 1'b1);
    vpc_f = 64'h1C;
    expect_out(2, "fl_pre_row0", 2'b01, 2'b01, 8'h07, 1'b0);
    fl_f = 1'b1;
    tick();
    fl_f = 1'b0;
    vpc_f = 64'h00;
    for (int k = 1; k <= 8; k++) begin
      expect_out(2, $sformatf("fl_walk_c%0d", k), 2'b00, (k == 1) ? 2'b01 : 2'b00, 8'h00, 1'b1);
      if (k == 3) begin
        fl_f = 1'b1; uv_f = 1'b1; upc_f = 64'h00; ug_f = 3'd0; ut_f = 1'b1;
      end
      tick();
      fl_f = 1'b0; uv_f = 1'b0;
    end
    for (int r = 0; r < 8; r++) begin
      vpc_f = 64'(r) << 2;
      expect_out(2, $sformatf("fl_post_row%0d", r), 2'b00, 2'b00, 8'h00, 1'b0);
      tick();
    end

    // Reset in cycle 4 of a flush
    upd_f(64'h1C, 3'd0, 1'b1);
    fl_f = 1'b1;
    tick();
    fl_f = 1'b0;
    vpc_f = 64'h1C;
    repeat (3) tick();
    rst = 1'b1;
    expect_out(2, "rst_mid_busy", 2'b00, 2'b01, 8'h00, 1'b1);
    tick();
    rst = 1'b0;
    expect_out(2, "rst_mid_cleared", 2'b00, 2'b00, 8'h00, 1'b0);
    upd_f(64'h1C, 3'd0, 1'b1);
    vpc_f = 64'h18;
    expect_out(2, "rst_then_update", 2'b01, 2'b01, 8'h01, 1'b0);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
